// File: rtl/ram_bist_pkg.sv
// Shared state encoding and RAM access constants for the RAM BIST controller.
package ram_bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WRITE,
      S_READ,
      S_CHECK,
      S_DONE
   } state_e;

   localparam logic RAM_WR = 1'b1;
   localparam logic RAM_RD = 1'b0;

endpackage

// File: rtl/ram_bist_checker.sv
// Read-back checker: holds the expected word for the read in flight, counts mismatches
// and latches the address of the first one.
module ram_bist_checker
   import ram_bist_pkg::*;
#(
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              cmp_en,
   input  logic [DATA_W-1:0] exp,
   input  logic [DATA_W-1:0] dout,
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] fail_addr
);

   logic [DATA_W-1:0] exp_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic              mismatch;

   // exp/addr describe the cycle about to start, so the registered copies line up
   // with the read whose data is sampled at the edge ending that cycle.
   assign mismatch = cmp_en && (dout != exp_q);

   always_comb begin
      err_cnt_d   = err_cnt_q;
      fail_addr_d = fail_addr_q;
      if (clear) begin
         err_cnt_d   = '0;
         fail_addr_d = '0;
      end else if (mismatch) begin
         err_cnt_d = err_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
         if (err_cnt_q == '0) begin
            fail_addr_d = addr_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q       <= '0;
         addr_q      <= '0;
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
      end else begin
         exp_q       <= exp;
         addr_q      <= addr;
         err_cnt_q   <= err_cnt_d;
         fail_addr_q <= fail_addr_d;
      end
   end

   assign err_cnt   = err_cnt_q;
   assign fail_addr = fail_addr_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM self-test initiator: clear, write PATTERN^addr to every word, read back and compare.
// All outputs come straight from flops loaded with next-state decode.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 8
) (
   input  logic              CLK,
   input  logic              CLR_N,
   input  logic              START,
   input  logic              ABORT,
   input  logic [DATA_W-1:0] PATTERN,
   output logic              RAM_CLR,
   output logic              RAM_R_W,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_DIN,
   input  logic [DATA_W-1:0] RAM_DOUT,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [ADDR_W:0]   ERR_CNT,
   output logic [ADDR_W-1:0] FAIL_ADDR
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] pattern_q, pattern_d;
   logic              pass_q, pass_d;
   logic              ram_clr_q, ram_clr_d;
   logic              ram_rw_q, ram_rw_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept;
   logic              cmp_en;
   logic [DATA_W-1:0] exp_next;
   logic [ADDR_W:0]   err_cnt;

   assign accept   = (state_q == S_IDLE) && START && !ABORT;
   // A read sampled at an aborting edge is discarded so ERR_CNT stays as it was.
   assign cmp_en   = (state_q == S_READ) && !ABORT;
   assign exp_next = pattern_q ^ DATA_W'(addr_d);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pattern_d = pattern_q;
      pass_d    = pass_q;
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d   = S_CLEAR;
               addr_d    = '0;
               pattern_d = PATTERN;
               pass_d    = 1'b0;
            end
         end
         S_CLEAR: begin
            state_d = S_WRITE;
            addr_d  = '0;
         end
         S_WRITE: begin
            if (addr_q == LAST_ADDR) begin
               state_d = S_READ;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_READ: begin
            if (addr_q == LAST_ADDR) begin
               state_d = S_CHECK;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_CHECK: begin
            state_d = S_DONE;
            pass_d  = (err_cnt == '0);
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            addr_d  = '0;
         end
      endcase
      if (ABORT) begin
         state_d   = S_IDLE;
         addr_d    = '0;
         pattern_d = pattern_q;
         pass_d    = 1'b0;
      end

      ram_clr_d = (state_d == S_CLEAR);
      ram_rw_d  = (state_d == S_WRITE) ? RAM_WR : RAM_RD;
      din_d     = (state_d == S_WRITE) ? (pattern_q ^ DATA_W'(addr_d)) : '0;
      busy_d    = (state_d == S_CLEAR) || (state_d == S_WRITE) ||
                  (state_d == S_READ)  || (state_d == S_CHECK);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         pattern_q <= '0;
         pass_q    <= 1'b0;
         ram_clr_q <= 1'b0;
         ram_rw_q  <= RAM_RD;
         din_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         pattern_q <= pattern_d;
         pass_q    <= pass_d;
         ram_clr_q <= ram_clr_d;
         ram_rw_q  <= ram_rw_d;
         din_q     <= din_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   ram_bist_checker #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_checker (
      .clk      (CLK),
      .rst_n    (CLR_N),
      .clear    (accept),
      .cmp_en   (cmp_en),
      .exp      (exp_next),
      .dout     (RAM_DOUT),
      .addr     (addr_d),
      .err_cnt  (err_cnt),
      .fail_addr(FAIL_ADDR)
   );

   assign RAM_CLR  = ram_clr_q;
   assign RAM_R_W  = ram_rw_q;
   assign RAM_ADDR = addr_q;
   assign RAM_DIN  = din_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign PASS     = pass_q;
   assign ERR_CNT  = err_cnt;

endmodule
